// File: rtl/count_scheduler.sv
// Job-level sequencer for the 16-lane match-count engine: issues line reads under a
// FIFO credit limit, buffers returned lines, feeds them one at a time and sums the counts.
module count_scheduler #(
  parameter int unsigned ADDR_W     = 42,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              job_start,
  input  logic [31:0]       job_object,
  input  logic [ADDR_W-1:0] job_base_addr,
  input  logic [31:0]       job_num_lines,
  output logic              job_busy,
  output logic              job_done,
  output logic [31:0]       job_total,
  output logic [31:0]       job_lines_done,
  output logic              job_overflow,
  output logic              rd_req_valid,
  input  logic              rd_req_ready,
  output logic [ADDR_W-1:0] rd_req_addr,
  input  logic              rd_rsp_valid,
  input  logic [511:0]      rd_rsp_data,
  output logic              eng_start,
  output logic [31:0]       eng_object,
  output logic [511:0]      eng_data_set,
  input  logic              eng_done,
  input  logic [31:0]       eng_result
);

  localparam int unsigned LINE_W = 512;
  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned SUM_W  = CNT_W + 1;

  typedef enum logic [1:0] {F_IDLE, F_WAIT, F_GAP} feed_state_e;

  feed_state_e       fstate, fstate_n;
  logic              busy_n, done_n, ovf_n, req_valid_n, start_n;
  logic [31:0]       total_n, lines_n, obj_n;
  logic [31:0]       num_lines, num_lines_n, issued, issued_n;
  logic [ADDR_W-1:0] base, base_n, addr_n;
  logic [CNT_W-1:0]  outstanding, outstanding_n, fifo_cnt, fifo_cnt_n;
  logic [PTR_W-1:0]  wr_ptr, wr_ptr_n, rd_ptr, rd_ptr_n;
  logic [LINE_W-1:0] data_n;
  logic [LINE_W-1:0] mem [FIFO_DEPTH];
  logic              accept, issue_fire, pop, push, rsp_dec;
  logic [32:0]       sum;
  logic [SUM_W-1:0]  credit_used;

  // Next-state for the feed FSM, job control, read credits and FIFO pointers
  always_comb begin
    accept      = job_start && !job_busy;
    issue_fire  = rd_req_valid && rd_req_ready;
    pop         = (fstate == F_IDLE) && job_busy && (fifo_cnt != '0);
    push        = rd_rsp_valid && ((fifo_cnt != CNT_W'(FIFO_DEPTH)) || pop);
    rsp_dec     = rd_rsp_valid && (outstanding != '0);
    sum         = {1'b0, job_total} + {1'b0, eng_result};

    fstate_n      = fstate;
    busy_n        = job_busy;
    done_n        = 1'b0;
    total_n       = job_total;
    lines_n       = job_lines_done;
    ovf_n         = job_overflow;
    start_n       = 1'b0;
    obj_n         = eng_object;
    data_n        = eng_data_set;
    num_lines_n   = num_lines;
    base_n        = base;
    issued_n      = issued + 32'(issue_fire);
    outstanding_n = outstanding + CNT_W'(issue_fire) - CNT_W'(rsp_dec);
    fifo_cnt_n    = fifo_cnt + CNT_W'(push) - CNT_W'(pop);
    wr_ptr_n      = wr_ptr + PTR_W'(push);
    rd_ptr_n      = rd_ptr + PTR_W'(pop);

    if (rd_rsp_valid && !push) ovf_n = 1'b1;

    unique case (fstate)
      F_IDLE: begin
        if (pop) begin
          fstate_n = F_WAIT;
          start_n  = 1'b1;
          data_n   = mem[rd_ptr];
        end
      end
      F_WAIT: begin
        if (eng_done) begin
          total_n  = sum[32] ? 32'hFFFF_FFFF : sum[31:0];
          lines_n  = job_lines_done + 32'd1;
          fstate_n = F_GAP;
          if (lines_n == num_lines) begin
            done_n = 1'b1;
            busy_n = 1'b0;
          end
        end
      end
      F_GAP:   fstate_n = F_IDLE;
      default: fstate_n = F_IDLE;
    endcase

    // A zero-length job completes immediately without ever going busy
    if (accept) begin
      obj_n         = job_object;
      base_n        = job_base_addr;
      num_lines_n   = job_num_lines;
      total_n       = '0;
      lines_n       = '0;
      ovf_n         = 1'b0;
      issued_n      = '0;
      outstanding_n = '0;
      fifo_cnt_n    = '0;
      wr_ptr_n      = '0;
      rd_ptr_n      = '0;
      busy_n        = (job_num_lines != 32'd0);
      done_n        = (job_num_lines == 32'd0);
    end

    credit_used = {1'b0, outstanding_n} + {1'b0, fifo_cnt_n};
    req_valid_n = busy_n && (issued_n < num_lines_n) && (credit_used < SUM_W'(FIFO_DEPTH));
    addr_n      = base_n + ADDR_W'(issued_n);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fstate         <= F_IDLE;
      job_busy       <= 1'b0;
      job_done       <= 1'b0;
      job_total      <= '0;
      job_lines_done <= '0;
      job_overflow   <= 1'b0;
      rd_req_valid   <= 1'b0;
      rd_req_addr    <= '0;
      eng_start      <= 1'b0;
      eng_object     <= '0;
      eng_data_set   <= '0;
      num_lines      <= '0;
      base           <= '0;
      issued         <= '0;
      outstanding    <= '0;
      fifo_cnt       <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
    end else begin
      fstate         <= fstate_n;
      job_busy       <= busy_n;
      job_done       <= done_n;
      job_total      <= total_n;
      job_lines_done <= lines_n;
      job_overflow   <= ovf_n;
      rd_req_valid   <= req_valid_n;
      rd_req_addr    <= addr_n;
      eng_start      <= start_n;
      eng_object     <= obj_n;
      eng_data_set   <= data_n;
      num_lines      <= num_lines_n;
      base           <= base_n;
      issued         <= issued_n;
      outstanding    <= outstanding_n;
      fifo_cnt       <= fifo_cnt_n;
      wr_ptr         <= wr_ptr_n;
      rd_ptr         <= rd_ptr_n;
    end
  end

  // Line storage needs no reset; occupancy is tracked by the pointers
  always_ff @(posedge clk) begin
    if (push && !accept) mem[wr_ptr] <= rd_rsp_data;
  end

endmodule
